alu_seq_ctrl: RTL

Micro-sequencer directly upstream of the ALU/accumulator stage. Holds a small loadable program and, after a start pulse, steps through it one instruction at a time. Each step drives the ALU opcode, both operands and the carry-in, then pulses the accumulator write enable. Accumulator output and registered carry feed back so instructions can chain on the running result.

---
 rtl/alu_seq_pkg.sv | 22 ++
 rtl/alu_seq_prog_mem.sv | 27 ++
 rtl/alu_seq_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU micro-sequencer: FSM states, instruction layout, word width.
package alu_seq_pkg;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_DONE} state_e;

    localparam int DEF_DATA_WIDTH   = 8;
    localparam int DEF_OPCODE_WIDTH = 3;

    // Instruction word at default widths, fields MSB to LSB
    typedef struct packed {
        logic [DEF_OPCODE_WIDTH-1:0] opcode;
        logic                        src_acc;
        logic                        use_carry;
        logic                        last;
        logic [DEF_DATA_WIDTH-1:0]   imm;
    } instr_t;

    function automatic int instr_width(input int opcode_width, input int data_width);
        return opcode_width + 3 + data_width;
    endfunction

endpackage

// File: rtl/alu_seq_prog_mem.sv
// Program store: one write port, one registered read port with write-through
// so a word written on the same edge as its read is returned.
module alu_seq_prog_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 14,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/alu_seq_ctrl.sv
// Micro-sequencer feeding the ALU/accumulator stage; two cycles per instruction.
// Optional ALU_SEQ_STEP_EN adds a step input that gates FETCH -> EXEC.
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int OPCODE_WIDTH = 3,
    parameter int PROG_DEPTH   = 16,
    localparam int AW = $clog2(PROG_DEPTH),
    localparam int IW = instr_width(OPCODE_WIDTH, DATA_WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst,
`ifdef ALU_SEQ_STEP_EN
    input  logic                    step,
`endif
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    input  logic                    prog_we,
    input  logic [AW-1:0]           prog_addr,
    input  logic [IW-1:0]           prog_wdata,
    input  logic [DATA_WIDTH-1:0]   operand_a,
    input  logic [DATA_WIDTH-1:0]   acc_in,
    input  logic                    carry_fb,
    output logic [OPCODE_WIDTH-1:0] alu_opcode,
    output logic [DATA_WIDTH-1:0]   input_data_0,
    output logic [DATA_WIDTH-1:0]   input_data_1,
    output logic                    carry_in,
    output logic                    accumulator_ce
);

    state_e                  state_q;
    logic [AW-1:0]           pc_q;
    logic                    busy_q, done_q, err_q, ce_q, cin_q;
    logic [OPCODE_WIDTH-1:0] op_q;
    logic [DATA_WIDTH-1:0]   d0_q, d1_q;

    logic [IW-1:0]           instr;
    logic [OPCODE_WIDTH-1:0] f_opcode;
    logic                    f_src_acc, f_use_carry, f_last;
    logic [DATA_WIDTH-1:0]   f_imm;
    logic                    step_ok, launch, advance, at_end, mem_re, mem_we;
    logic [AW-1:0]           mem_raddr;

`ifdef ALU_SEQ_STEP_EN
    assign step_ok = step;
`else
    assign step_ok = 1'b1;
`endif

    assign f_opcode    = instr[IW-1 -: OPCODE_WIDTH];
    assign f_src_acc   = instr[DATA_WIDTH+2];
    assign f_use_carry = instr[DATA_WIDTH+1];
    assign f_last      = instr[DATA_WIDTH];
    assign f_imm       = instr[DATA_WIDTH-1:0];

    assign at_end  = (pc_q == AW'(PROG_DEPTH-1));
    assign launch  = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign advance = (state_q == S_EXEC) && !f_last && !at_end;

    // Read is issued on the edge entering FETCH, so the word is ready during FETCH
    assign mem_re    = launch || advance;
    assign mem_raddr = launch ? '0 : pc_q + AW'(1);
    assign mem_we    = prog_we && !busy_q;

    alu_seq_prog_mem #(.DEPTH(PROG_DEPTH), .WIDTH(IW), .AW(AW)) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (prog_addr),
        .wdata_i (prog_wdata),
        .re_i    (mem_re),
        .raddr_i (mem_raddr),
        .rdata_o (instr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ce_q    <= 1'b0;
            cin_q   <= 1'b0;
            op_q    <= '0;
            d0_q    <= '0;
            d1_q    <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            ce_q   <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q <= S_FETCH;
                        pc_q    <= '0;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_FETCH: begin
                    // acc_in/carry_fb sampled here already reflect the previous EXEC
                    if (step_ok) begin
                        state_q <= S_EXEC;
                        op_q    <= f_opcode;
                        d0_q    <= f_src_acc ? acc_in : operand_a;
                        d1_q    <= f_imm;
                        cin_q   <= f_use_carry & carry_fb;
                        ce_q    <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (f_last) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else if (at_end) begin
                        state_q <= S_IDLE;
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= S_FETCH;
                        pc_q    <= pc_q + AW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;
    assign accumulator_ce = ce_q;
    assign carry_in       = cin_q;
    assign alu_opcode     = op_q;
    assign input_data_0   = d0_q;
    assign input_data_1   = d1_q;

endmodule
